lsu_wb_stage: RTL and testbench

- Memory-access and writeback stage that sits directly downstream of the execute ALU.
- Accepts one execute result per transaction: ALU result, data address, read/write enables, funct3, destination register, register-write enable.
- Performs byte/half/word loads and stores over a req/ack data-memory port, with lane alignment and sign extension.
- Drives the register-file write port; flags misaligned or illegal accesses and memory timeouts.

---
 rtl/lsu_wb_stage.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_stage.sv
// Purpose: memory-access/writeback stage after the execute ALU (byte/half/word loads and stores, regfile write, exceptions).
// Latency: non-memory or faulting ops complete 1 cycle after acceptance; memory ops complete the cycle after mem_ack.
// Backpressure: in_ready is high only in IDLE; mem_req holds until mem_ack or TIMEOUT_CYC cycles elapse.
module lsu_wb_stage #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_out,
  input  logic [31:0] d_add,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [2:0]  f3,
  input  logic [4:0]  alu_rd,
  input  logic        alu_reg_w_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misalign,
  output logic        exc_bus,
  output logic [31:0] exc_addr
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Transaction captured at acceptance
  logic [31:0] alu_out_q;
  logic [31:0] d_add_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q;

  // Registered outputs
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_bus_q, exc_bus_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        illegal_in;
  logic        misalign_in;
  logic [15:0] lane;
  logic [31:0] ld_val;

  // Classify the incoming op: illegal encodings and misaligned half/word accesses
  always_comb begin
    illegal_in = 1'b0;
    if (d_r_en && d_w_en)
      illegal_in = 1'b1;
    else if (d_r_en)
      illegal_in = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else if (d_w_en)
      illegal_in = f3[2] || (f3 == 3'b011);
    misalign_in = (d_r_en || d_w_en) &&
                  (((f3[1:0] == 2'b01) && d_add[0]) ||
                   ((f3[1:0] == 2'b10) && (d_add[1:0] != 2'b00)));
  end

  // Pick the addressed lane of read data and extend it according to funct3
  always_comb begin
    lane   = 16'(mem_rdata >> {d_add_q[1:0], 3'b000});
    ld_val = mem_rdata;
    case (f3_q)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'd0, lane[7:0]};
      3'b101:  ld_val = {16'd0, lane[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  // Memory port: request and its attributes are driven only while in MEM
  always_comb begin
    mem_req   = (state_q == S_MEM);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? {d_add_q[31:2], 2'b00} : 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    if (mem_req) begin
      case (f3_q[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << d_add_q[1:0];
          mem_wdata = {4{alu_out_q[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << {d_add_q[1], 1'b0};
          mem_wdata = {2{alu_out_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = alu_out_q;
        end
      endcase
    end
  end

  // Next-state logic: pulses are set only on the transition into DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_en_d    = 1'b0;
    exc_mis_d  = 1'b0;
    exc_bus_d  = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    exc_addr_d = exc_addr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!d_r_en && !d_w_en) begin
            state_d   = S_DONE;
            wb_en_d   = alu_reg_w_en && (alu_rd != 5'd0);
            wb_rd_d   = alu_rd;
            wb_data_d = alu_out;
          end else if (illegal_in || misalign_in) begin
            state_d    = S_DONE;
            exc_mis_d  = 1'b1;
            exc_addr_d = d_add;
          end else begin
            state_d = S_MEM;
            cnt_d   = 8'd0;
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            wb_en_d   = (rd_q != 5'd0);
            wb_rd_d   = rd_q;
            wb_data_d = ld_val;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_DONE;
          exc_bus_d  = 1'b1;
          exc_addr_d = d_add_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      exc_mis_q  <= 1'b0;
      exc_bus_q  <= 1'b0;
      exc_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      exc_mis_q  <= exc_mis_d;
      exc_bus_q  <= exc_bus_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  // Capture the execute result when it is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= 32'd0;
      d_add_q   <= 32'd0;
      f3_q      <= 3'd0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
    end else if (in_valid && in_ready) begin
      alu_out_q <= alu_out;
      d_add_q   <= d_add;
      f3_q      <= f3;
      rd_q      <= alu_rd;
      we_q      <= d_w_en;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign exc_misalign = exc_mis_q;
  assign exc_bus      = exc_bus_q;
  assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Purpose: self-checking bench for lsu_wb_stage (directed cases plus random ops against a reference model).
// Latency: checks cycle-by-cycle timing of DONE, mem_req duration and timeout.
// Backpressure: memory ack delay is randomized; in_valid is toggled with junk while busy.
module tb_lsu_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [31:0] d_add;
  logic        d_r_en;
  logic        d_w_en;
  logic [2:0]  f3;
  logic [4:0]  alu_rd;
  logic        alu_reg_w_en;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign;
  logic        exc_bus;
  logic [31:0] exc_addr;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_exc_addr = 32'd0;

  lsu_wb_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .d_add(d_add), .d_r_en(d_r_en), .d_w_en(d_w_en),
    .f3(f3), .alu_rd(alu_rd), .alu_reg_w_en(alu_reg_w_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_inputs();
    in_valid     = 1'($urandom);
    alu_out      = $urandom;
    d_add        = $urandom;
    d_r_en       = 1'($urandom);
    d_w_en       = 1'($urandom);
    f3           = 3'($urandom);
    alu_rd       = 5'($urandom);
    alu_reg_w_en = 1'($urandom);
  endtask

  // One complete transaction starting in an IDLE cycle; ends in the following IDLE cycle.
  // dly = MEM cycle (1-based) in which mem_ack is presented.
  task automatic run_txn(input logic r, input logic w, input logic [2:0] fv,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rwen, input int dly,
                         input logic [31:0] rdata);
    int          size, off, c;
    logic        is_mem, legal, fault, done;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    logic [63:0] raw, mask, val;

    // Reference model
    is_mem = r || w;
    size   = 1 << fv[1:0];
    off    = int'(addr[1:0]);
    if (r && w)  legal = 1'b0;
    else if (r)  legal = (fv inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else if (w)  legal = (fv inside {3'd0, 3'd1, 3'd2});
    else         legal = 1'b1;
    fault = is_mem && (!legal || ((addr % size) != 0));
    for (int i = 0; i < 4; i++) begin
      ebe[i]          = (i >= off) && (i < off + size);
      ewd[8*i +: 8]   = data[8*(i % size) +: 8];
    end
    raw  = {32'd0, rdata} >> (8 * off);
    mask = (size >= 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    val  = raw & mask;
    if (!fv[2] && size < 4 && val[8*size-1]) val = val | ~mask;
    eld  = val[31:0];

    // IDLE cycle: must be ready, no pulses; stray ack is ignored
    chk("idle_ready", in_ready, 1);
    chk("idle_req", mem_req, 0);
    chk("idle_wb_en", wb_en, 0);
    chk("idle_exc_mis", exc_misalign, 0);
    chk("idle_exc_bus", exc_bus, 0);
    chk("idle_exc_addr", exc_addr, exp_exc_addr);
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    in_valid = 1'b1; d_r_en = r; d_w_en = w; f3 = fv; d_add = addr;
    alu_out = data; alu_rd = rd; alu_reg_w_en = rwen;
    tick();
    mem_ack = 1'b0;
    junk_inputs();

    if (is_mem && !fault) begin
      done = 1'b0;
      c = 1;
      while (!done) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, w);
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_be", mem_be, ebe);
        if (w) chk("mem_wdata", mem_wdata, ewd);
        chk("busy_ready", in_ready, 0);
        chk("busy_wb_en", wb_en, 0);
        mem_ack   = (c == dly);
        mem_rdata = (c == dly) ? rdata : $urandom;
        tick();
        mem_ack = 1'b0;
        junk_inputs();
        if (c == dly || c == TO) done = 1'b1;
        c++;
      end
    end

    // DONE cycle
    chk("done_req", mem_req, 0);
    chk("done_ready", in_ready, 0);
    if (!is_mem) begin
      chk("alu_wb_en", wb_en, rwen && (rd != 0));
      chk("alu_wb_rd", wb_rd, rd);
      chk("alu_wb_data", wb_data, data);
      chk("alu_exc_mis", exc_misalign, 0);
      chk("alu_exc_bus", exc_bus, 0);
    end else if (fault) begin
      exp_exc_addr = addr;
      chk("flt_exc_mis", exc_misalign, 1);
      chk("flt_exc_bus", exc_bus, 0);
      chk("flt_wb_en", wb_en, 0);
    end else if (dly > TO) begin
      exp_exc_addr = addr;
      chk("to_exc_bus", exc_bus, 1);
      chk("to_exc_mis", exc_misalign, 0);
      chk("to_wb_en", wb_en, 0);
    end else if (r) begin
      chk("ld_wb_en", wb_en, rd != 0);
      chk("ld_wb_rd", wb_rd, rd);
      chk("ld_wb_data", wb_data, eld);
      chk("ld_exc_bus", exc_bus, 0);
      chk("ld_exc_mis", exc_misalign, 0);
    end else begin
      chk("st_wb_en", wb_en, 0);
      chk("st_exc_bus", exc_bus, 0);
      chk("st_exc_mis", exc_misalign, 0);
    end
    chk("done_exc_addr", exc_addr, exp_exc_addr);
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    alu_out = 32'd0; d_add = 32'd0; d_r_en = 1'b0; d_w_en = 1'b0;
    f3 = 3'd0; alu_rd = 5'd0; alu_reg_w_en = 1'b0;
    repeat (3) tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_exc_mis", exc_misalign, 0);
    chk("rst_exc_bus", exc_bus, 0);
    chk("rst_exc_addr", exc_addr, 0);
    rst = 1'b0;
    tick();

    // addi rd=5 and rd=0
    run_txn(0, 0, 3'b000, 32'h0, 32'h0000_002A, 5'd5, 1, 1, 32'h0);
    run_txn(0, 0, 3'b000, 32'h0, 32'h0000_002A, 5'd0, 1, 1, 32'h0);
    // sb with ack in the 3rd request cycle
    run_txn(0, 1, 3'b000, 32'h0000_1003, 32'h1234_56AB, 5'd7, 0, 3, 32'h0);
    // lb / lbu / lh
    run_txn(1, 0, 3'b000, 32'h0000_2001, 32'h0, 5'd3, 0, 1, 32'h1122_8033);
    chk("lb_value", wb_data, 32'hFFFF_FF80);
    run_txn(1, 0, 3'b100, 32'h0000_2001, 32'h0, 5'd3, 0, 2, 32'h1122_8033);
    chk("lbu_value", wb_data, 32'h0000_0080);
    run_txn(1, 0, 3'b001, 32'h0000_2002, 32'h0, 5'd4, 0, 1, 32'h1122_8033);
    chk("lh_value", wb_data, 32'h0000_1122);
    // misaligned lw and illegal funct3 load
    run_txn(1, 0, 3'b010, 32'h0000_3002, 32'h0, 5'd6, 1, 1, 32'h0);
    run_txn(1, 0, 3'b011, 32'h0000_3000, 32'h0, 5'd6, 1, 1, 32'h0);
    // timeout, then ack exactly in the last allowed cycle
    run_txn(1, 0, 3'b010, 32'h0000_4000, 32'h0, 5'd8, 0, 50, 32'hDEAD_BEEF);
    run_txn(1, 0, 3'b010, 32'h0000_4004, 32'h0, 5'd8, 0, TO, 32'hCAFE_F00D);
    chk("ack_last_value", wb_data, 32'hCAFE_F00D);

    // reset in the 2nd MEM cycle; a late ack must not write back
    in_valid = 1'b1; d_r_en = 1'b1; d_w_en = 1'b0; f3 = 3'b010;
    d_add = 32'h0000_5000; alu_rd = 5'd9; alu_reg_w_en = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("mrst_req1", mem_req, 1);
    tick();
    chk("mrst_req2", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_exc_addr = 32'd0;
    chk("mrst_req", mem_req, 0);
    chk("mrst_ready", in_ready, 1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("mrst_wb_en1", wb_en, 0);
    chk("mrst_req_after", mem_req, 0);
    tick();
    chk("mrst_wb_en2", wb_en, 0);
    chk("mrst_ready2", in_ready, 1);

    // randomized ops against the model
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic rr, ww;
      kind = $urandom_range(0, 9);
      rr = (kind >= 2 && kind <= 5) || kind == 9;
      ww = (kind >= 6 && kind <= 8) || kind == 9;
      run_txn(rr, ww, 3'($urandom), $urandom, $urandom, 5'($urandom),
              1'($urandom), $urandom_range(1, TO + 2), $urandom);
    end
    chk("final_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
